pipeline_controller: RTL
========================

# pipeline_controller

Control unit for the 3-stage (IF / ID+EX / MEM+WB) pipeline datapath. It decodes the instruction held in IF_ID, drives the ALU and branch controls for the execute stage, and holds the memory/write-back controls in a register aligned with EX_MEM. It also issues the IF_ID flush on taken branches and runs a small run/halt state machine that suppresses architectural writes after an illegal instruction or ECALL.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- inst_control  in  7  opcode of the decode-stage instruction, instq[6:0]
- inst_alu  in  10  {funct7, funct3} of the decode-stage instruction
- zero_flag  in  1  ALU zero result, same cycle
- alu_op  out  4  ALU operation; comb.
- alu_src  out  1  1 selects the immediate; comb.
- sel  out  1  1 makes next PC = branch target; comb.
- flush  out  1  clears IF_ID at the next edge; comb.
- regwq, memwq, memrq, mem2regq  out  1 each  registered MEM/WB controls
- halted  out  1  registered; 1 in HALT
- cycle_cnt, retire_cnt  out  32 each; flush_cnt  out  16  (PERF_CNT_EN only)

## Operation
- Supported opcodes:
  - R 0110011
  - I-ALU 0010011
  - LOAD 0000011
  - STORE 0100011
  - BRANCH 1100011
  - ECALL 1110011
- Any other opcode in RUN is illegal.
- alu_op encoding: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, SLT 1000.
- R-type: funct3 selects the operation. funct7[5] (inst_alu[8]) selects SUB for funct3 000 and SRA for funct3 101.
- I-ALU: same mapping as R-type, but funct7[5] is honoured only for funct3 101.
- LOAD and STORE: ADD, with alu_src=1. I-ALU also drives alu_src=1.
- BRANCH:
  - alu_op=SUB, alu_src=0.
  - taken = (funct3==000 & zero_flag) | (funct3==001 & ~zero_flag).
  - Other funct3 values are never taken and are legal.
- Decode-stage valid: ex_valid = (state==RUN) & ~flush_q. flush_q is flush registered, so the bubble that follows a flush is known invalid.
- Control outputs when ex_valid=1:
  - sel = flush = taken.
  - Next-stage controls: regw = R | I-ALU | LOAD; memw = STORE; memr = LOAD; mem2reg = LOAD.
- When ex_valid=0: sel=0, flush=0, next-stage controls=0. alu_op and alu_src still decode (harmless).
- State machine (2-bit state):
  - FILL → RUN after 1 cycle. FILL covers the cycle where IF_ID still holds its reset contents.
  - RUN → HALT when ex_valid and the opcode is ECALL or illegal. That instruction's controls are forced to 0.
  - HALT is left only by rst.
  - In HALT: flush=1 continuously, sel=0, next-stage controls=0. Older instructions already in MEM still complete.

## Timing
- Reset (async, rst=0):
  - state=FILL, flush_q=0.
  - regwq, memwq, memrq, mem2regq, halted = 0.
  - Counters = 0.
- alu_op, alu_src, sel, flush are combinational from inst_control, inst_alu, zero_flag and state. All are 0 during reset.
- regwq/memwq/memrq/mem2regq update on the edge that loads EX_MEM: 1-cycle latency, aligned with instq1.
- Taken branch in cycle N:
  - The edge ending N loads the target PC and flushes IF_ID.
  - Cycle N+1 has ex_valid=0 via flush_q.
  - Fetch resumes at the target.
  - Penalty is 1 cycle.
- Back-to-back branches: a branch in the cycle after a taken branch is a bubble, so it is never taken.
- halted asserts on the edge after ECALL or illegal detection.
- rst asserted mid-operation: all of the above reset values apply immediately (asynchronous), including counters.

## Configuration
- PERF_CNT_EN defined:
  - cycle_cnt increments every cycle outside reset, including HALT.
  - retire_cnt increments on each edge where ex_valid=1 and the instruction is legal and not ECALL.
  - flush_cnt increments on each taken branch.
  - All three wrap modulo 2^width.
- PERF_CNT_EN undefined: the three ports and their registers are absent. All other behaviour is identical.

## Test plan
- Reset release, then ADD (opcode 0110011, inst_alu=0000000_000):
  - Cycle 1 (FILL): all controls 0.
  - Cycle 2: alu_op=0010, alu_src=0.
  - Next cycle: regwq=1, memwq=0.
- SUB (inst_alu=0100000_000) -> alu_op=0110. SRAI (opcode 0010011, inst_alu=0100000_101) -> alu_op=0111, alu_src=1.
- LW, then SW:
  - After LW: memrq=1, mem2regq=1, regwq=1.
  - After SW: memwq=1, regwq=0, alu_op=0010, alu_src=1.
- BEQ with zero_flag=1:
  - Same cycle: sel=1, flush=1.
  - Next cycle: an ADD present in decode yields regwq=0 one cycle later.
- BEQ with zero_flag=0 -> sel=0, flush=0. BNE with zero_flag=0 -> sel=1.
- Opcode 0000000 in RUN:
  - Its controls are 0.
  - halted=1 after the next edge; flush=1 thereafter.
  - A following ADD never raises regwq.
  - rst=0 clears halted asynchronously.
  - With PERF_CNT_EN, retire_cnt and flush_cnt freeze while cycle_cnt keeps counting.

Source files
------------

// File: rtl/pipeline_controller.sv
// -----------------------------------------------------------------------------
// pipeline_controller
//
// Control unit for the 3-stage (IF / ID+EX / MEM+WB) pipeline. Decodes the
// instruction held in IF_ID, drives the execute-stage ALU and branch controls,
// registers the MEM/WB controls alongside EX_MEM, flushes IF_ID on taken
// branches and halts on an illegal instruction or ECALL.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-low reset
//   inst_control in   [6:0] opcode of the decode-stage instruction
//   inst_alu     in   [9:0] {funct7, funct3} of the decode-stage instruction
//   zero_flag    in   ALU zero result, same cycle
//   alu_op       out  [3:0] ALU operation (combinational)
//   alu_src      out  1 selects the immediate (combinational)
//   sel          out  1 makes next PC the branch target (combinational)
//   flush        out  clears IF_ID at the next edge (combinational)
//   regwq, memwq, memrq, mem2regq  out  registered MEM/WB controls
//   halted       out  registered, 1 while in HALT
//   cycle_cnt, retire_cnt [31:0], flush_cnt [15:0]  out  performance
//                counters, present only when PERF_CNT_EN is defined
//
// Build option: define PERF_CNT_EN to add the performance counters.
// -----------------------------------------------------------------------------
module pipeline_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  inst_control,
    input  logic [9:0]  inst_alu,
    input  logic        zero_flag,
    output logic [3:0]  alu_op,
    output logic        alu_src,
    output logic        sel,
    output logic        flush,
    output logic        regwq,
    output logic        memwq,
    output logic        memrq,
    output logic        mem2regq,
`ifdef PERF_CNT_EN
    output logic        halted,
    output logic [31:0] cycle_cnt,
    output logic [31:0] retire_cnt,
    output logic [15:0] flush_cnt
`else
    output logic        halted
`endif
);

    typedef enum logic [1:0] {
        ST_FILL = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_ECALL  = 7'b1110011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SRA = 4'b0111;
    localparam logic [3:0] ALU_SLT = 4'b1000;

    state_t     state;
    logic       flush_q;

    logic [2:0] funct3;
    logic       funct7_b5;
    logic       unused_funct7;

    logic       op_r, op_i, op_load, op_store, op_branch, op_ecall, op_legal;
    logic [3:0] alu_op_dec;
    logic       alu_src_dec;
    logic       taken;
    logic       ex_valid;
    logic       halt_req;
    logic       wr_en;

    assign funct3        = inst_alu[2:0];
    assign funct7_b5     = inst_alu[8];
    assign unused_funct7 = ^{inst_alu[9], inst_alu[7:3]};

    assign op_r      = (inst_control == OPC_R);
    assign op_i      = (inst_control == OPC_I);
    assign op_load   = (inst_control == OPC_LOAD);
    assign op_store  = (inst_control == OPC_STORE);
    assign op_branch = (inst_control == OPC_BRANCH);
    assign op_ecall  = (inst_control == OPC_ECALL);
    assign op_legal  = op_r | op_i | op_load | op_store | op_branch | op_ecall;

    // funct3 -> ALU operation; funct7[5] picks SUB only for R-type, SRA for both.
    always_comb begin
        alu_op_dec  = ALU_AND;
        alu_src_dec = 1'b0;
        if (op_r || op_i) begin
            alu_src_dec = op_i;
            case (funct3)
                3'b000:  alu_op_dec = (op_r && funct7_b5) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_op_dec = ALU_SLL;
                3'b010:  alu_op_dec = ALU_SLT;
                3'b011:  alu_op_dec = ALU_SLT;
                3'b100:  alu_op_dec = ALU_XOR;
                3'b101:  alu_op_dec = funct7_b5 ? ALU_SRA : ALU_SRL;
                3'b110:  alu_op_dec = ALU_OR;
                default: alu_op_dec = ALU_AND;
            endcase
        end else if (op_load || op_store) begin
            alu_op_dec  = ALU_ADD;
            alu_src_dec = 1'b1;
        end else if (op_branch) begin
            alu_op_dec  = ALU_SUB;
            alu_src_dec = 1'b0;
        end
    end

    assign taken = op_branch &
                   (((funct3 == 3'b000) & zero_flag) |
                    ((funct3 == 3'b001) & ~zero_flag));

    // The slot after a flush holds a squashed instruction.
    assign ex_valid = (state == ST_RUN) & ~flush_q;
    assign halt_req = ex_valid & (op_ecall | ~op_legal);
    assign wr_en    = ex_valid & ~halt_req;

    // alu_op/alu_src are forced low while reset is held.
    assign alu_op  = rst ? alu_op_dec : '0;
    assign alu_src = rst & alu_src_dec;
    assign sel     = ex_valid & taken;
    assign flush   = (state == ST_HALT) | (ex_valid & taken);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_FILL;
            flush_q  <= 1'b0;
            regwq    <= 1'b0;
            memwq    <= 1'b0;
            memrq    <= 1'b0;
            mem2regq <= 1'b0;
            halted   <= 1'b0;
        end else begin
            flush_q  <= flush;
            regwq    <= wr_en & (op_r | op_i | op_load);
            memwq    <= wr_en & op_store;
            memrq    <= wr_en & op_load;
            mem2regq <= wr_en & op_load;
            case (state)
                ST_FILL: state <= ST_RUN;
                ST_RUN: begin
                    if (halt_req) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                    end
                end
                ST_HALT: halted <= 1'b1;
                default: state <= ST_FILL;
            endcase
        end
    end

`ifdef PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt  <= '0;
            retire_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (ex_valid && op_legal && !op_ecall)
                retire_cnt <= retire_cnt + 32'd1;
            if (ex_valid && taken)
                flush_cnt <= flush_cnt + 16'd1;
        end
    end
`endif

endmodule
